// File: rtl/data_unpack_pkg.sv
// Shared definitions for the 32-bit word to 7-bit packet unpacker controller.
// Holds the datapath widths, the refill threshold, the FSM state type and
// the datapath control bundle driven by the controller.
package data_unpack_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned PKT_W     = 7;
    localparam int unsigned CNT_W     = 5;
    // Last packet of a word is taken once count reaches this value.
    localparam int unsigned REFILL_TH = WORD_W - PKT_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_REFILL = 2'd2
    } state_e;

    // Per-cycle strobes towards the existing datapath.
    typedef struct packed {
        logic data_rst;
        logic data_load;
        logic data_overflow_load;
        logic count_set;
        logic count_en;
    } dp_ctrl_t;

endpackage

// File: rtl/data_unpack_ctrl.sv
// Controller for the word-to-packet unpacker. Sequences word loads and
// packet emission for an external datapath that holds the word buffer, a
// 6-bit overflow register and the bit-position counter.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream word handshake
//   out_valid / out_ready downstream packet handshake
//   flush                 synchronous restart of packet alignment
//   count                 datapath counter (MSB position of current packet)
//   data_rst, data_load, data_overflow_load, count_set, count_en
//                         datapath strobes
//   busy                  controller not in IDLE
module data_unpack_ctrl #(
    parameter int unsigned WORD_W = data_unpack_pkg::WORD_W,
    parameter int unsigned PKT_W  = data_unpack_pkg::PKT_W,
    parameter int unsigned CNT_W  = data_unpack_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    input  logic [CNT_W-1:0] count,
    output logic             data_rst,
    output logic             data_load,
    output logic             data_overflow_load,
    output logic             count_set,
    output logic             count_en,
    output logic             busy
);
    import data_unpack_pkg::*;

    localparam logic [CNT_W-1:0] REFILL_CNT = CNT_W'(WORD_W - PKT_W);

    state_e   state_q, state_d;
    dp_ctrl_t ctl;
    logic     rdy;
    logic     vld;
    logic     last_pkt;

    // Current packet is the last one fully contained in the buffered word.
    assign last_pkt = (count >= REFILL_CNT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake/datapath strobes.
    always_comb begin
        state_d = state_q;
        ctl     = '0;
        rdy     = 1'b0;
        vld     = 1'b0;
        if (flush) begin
            ctl.data_rst  = 1'b1;
            ctl.count_en  = 1'b1;
            ctl.count_set = 1'b1;
            state_d       = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rdy = 1'b1;
                    if (in_valid) begin
                        ctl.data_load = 1'b1;
                        ctl.count_en  = 1'b1;
                        ctl.count_set = 1'b1;
                        state_d       = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    vld = 1'b1;
                    // A new word is only taken alongside the last packet, so
                    // a waiting word refills with no bubble cycle.
                    rdy = out_ready & last_pkt;
                    if (out_ready) begin
                        ctl.count_en = 1'b1;
                        if (last_pkt) begin
                            if (in_valid) begin
                                ctl.data_load          = 1'b1;
                                ctl.data_overflow_load = 1'b1;
                            end else begin
                                state_d = ST_REFILL;
                            end
                        end
                    end
                end
                ST_REFILL: begin
                    rdy = 1'b1;
                    if (in_valid) begin
                        ctl.data_load          = 1'b1;
                        ctl.data_overflow_load = 1'b1;
                        state_d                = ST_EMIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Everything is forced low while reset is held, including IDLE's ready.
    assign in_ready           = rst_n & rdy;
    assign out_valid          = rst_n & vld;
    assign data_rst           = rst_n & ctl.data_rst;
    assign data_load          = rst_n & ctl.data_load;
    assign data_overflow_load = rst_n & ctl.data_overflow_load;
    assign count_set          = rst_n & ctl.count_set;
    assign count_en           = rst_n & ctl.count_en;
    assign busy               = rst_n & (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_unpack_ctrl.sv
// Bench for data_unpack_ctrl: a behavioural datapath (buffer, overflow,
// counter) closes the loop around the controller; a bitstream scoreboard
// predicts every packet and a monitor compares on each packet transfer.
module tb_data_unpack_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [4:0]  count;
    logic        data_rst;
    logic        data_load;
    logic        data_overflow_load;
    logic        count_set;
    logic        count_en;
    logic        busy;

    logic [31:0] data_in;
    logic [31:0] dp_buf;
    logic [5:0]  dp_ovf;
    logic [4:0]  dp_cnt;
    logic [37:0] dp_cat;
    logic [6:0]  data_out;

    int          n_cmp   = 0;
    int          n_err   = 0;
    int          pkt_cnt = 0;
    int          cyc     = 0;
    logic [6:0]  exp_q[$];
    bit          bq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_unpack_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .flush              (flush),
        .count              (count),
        .data_rst           (data_rst),
        .data_load          (data_load),
        .data_overflow_load (data_overflow_load),
        .count_set          (count_set),
        .count_en           (count_en),
        .busy               (busy)
    );

    // Behavioural datapath: packet MSB sits at bit 'count' of the buffer,
    // with the overflow bits extending the buffer below bit 0.
    assign count    = dp_cnt;
    assign dp_cat   = {dp_buf, dp_ovf};
    assign data_out = dp_cat[dp_cnt +: 7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_buf <= '0;
            dp_ovf <= '0;
            dp_cnt <= '0;
        end else begin
            if (data_rst) begin
                dp_buf <= '0;
                dp_ovf <= '0;
            end else begin
                if (data_overflow_load) dp_ovf <= dp_buf[31:26];
                if (data_load)          dp_buf <= data_in;
            end
            if (count_en) dp_cnt <= count_set ? 5'd6 : dp_cnt + 5'd7;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serialise an accepted word LSB first and cut complete packets.
    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) bq.push_back(w[i]);
        while (bq.size() >= 7) begin
            logic [6:0] p;
            for (int j = 0; j < 7; j++) p[j] = bq.pop_front();
            exp_q.push_back(p);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        bq.delete();
    endtask

    // Entered at a falling edge; returns at the falling edge after transfer.
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        data_in  = w;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("word_accept", in_ready, 1);
        if (in_ready) push_word(w);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_refill(input int lim);
        int n = 0;
        #1;
        while (!(busy && !out_valid) && n < lim) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reach_refill", busy && !out_valid, 1);
    endtask

    // Flush with both handshakes offered; nothing may transfer.
    task automatic do_flush();
        int n0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_data_rst", data_rst, 1);
        chk("flush_count_set", {count_en, count_set}, 2'b11);
        chk("flush_no_load", {data_load, data_overflow_load}, 2'b00);
        clear_sb();
        n0 = pkt_cnt;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_idle", {busy, in_ready}, 2'b01);
        chk("flush_count", count, 6);
        chk("flush_no_pkt", pkt_cnt - n0, 0);
        @(negedge clk);
    endtask

    // Monitor: compares every packet transfer and checks stall stability.
    initial begin
        logic       stall_v = 1'b0;
        logic [6:0] stall_d = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stall_v = 1'b0;
            end else begin
                if (stall_v && !flush) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", data_out, stall_d);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pkt", data_out, 32'hFFFF_FFFF);
                    end else begin
                        chk("packet", data_out, exp_q.pop_front());
                    end
                    pkt_cnt++;
                end
                stall_v = out_valid && !out_ready;
                stall_d = data_out;
            end
        end
    end

    logic [31:0] words_a[7] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_A5A5, 32'h0F0F_0F0F,
                                32'hCAFE_BABE, 32'h8000_0001, 32'h1357_9BDF};
    logic [31:0] words_b[7] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h5555_AAAA, 32'h7654_3210,
                                32'h0BAD_F00D, 32'hC3C3_3C3C, 32'h8421_1248};

    initial begin
        int  n0;
        int  c0;
        bit  done;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        data_in   = '0;

        // Reset: all outputs low even though IDLE would offer ready.
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid_busy", {out_valid, busy}, 2'b00);
        chk("rst_ctrl", {data_rst, data_load, data_overflow_load, count_set, count_en}, 5'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", {busy, in_ready}, 2'b01);
        @(negedge clk);

        // Single word 0x7F: packets at counts 6,13,20,27 then REFILL.
        out_ready = 1'b1;
        n0 = pkt_cnt;
        send_word(32'h0000_007F);
        #1;
        chk("first_valid", out_valid, 1);
        chk("first_count", count, 6);
        chk("first_pkt", data_out, 7'h7F);
        wait_refill(20);
        chk("refill_count", count, 2);
        chk("refill_in_ready", in_ready, 1);
        chk("single_word_pkts", pkt_cnt - n0, 4);
        @(negedge clk);
        do_flush();

        // Seven words back to back: 32 packets, no bubbles, count back to 6.
        out_ready = 1'b1;
        n0 = pkt_cnt;
        send_word(words_a[0]);
        c0 = cyc;
        for (int i = 1; i < 7; i++) send_word(words_a[i]);
        wait_refill(100);
        chk("stream_pkts", pkt_cnt - n0, 32);
        chk("stream_cycles", cyc - c0, 32);
        chk("stream_count", count, 6);
        chk("stream_residue", bq.size(), 0);
        @(negedge clk);
        do_flush();

        // Word gap at count 27: next packet joins new[2:0] with old[31:28].
        out_ready = 1'b1;
        send_word(32'hF000_0000);
        wait_refill(20);
        chk("gap_out_valid", out_valid, 0);
        @(negedge clk);
        send_word(32'h0000_0005);
        #1;
        chk("join_valid", out_valid, 1);
        chk("join_pkt", data_out, 7'h5F);
        wait_refill(20);
        @(negedge clk);
        do_flush();

        // Random downstream backpressure.
        n0   = pkt_cnt;
        done = 1'b0;
        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 7; i++) send_word(words_b[i]);
                wait_refill(1000);
                done = 1'b1;
            end
        join
        out_ready = 1'b1;
        chk("bp_pkts", pkt_cnt - n0, 32);
        @(negedge clk);
        do_flush();

        // Flush in EMIT with both handshakes offered.
        out_ready = 1'b0;
        send_word(32'h3C3C_3C3C);
        #1;
        chk("emit_before_flush", {busy, out_valid}, 2'b11);
        @(negedge clk);
        do_flush();

        // Asynchronous reset between edges in EMIT, then a clean restart.
        out_ready = 1'b0;
        send_word(32'h1111_2222);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {out_valid, busy, in_ready}, 3'b000);
        chk("async_rst_ctrl", {data_rst, data_load, count_en}, 3'b000);
        clear_sb();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("restart_idle", {busy, in_ready}, 2'b01);
        @(negedge clk);
        out_ready = 1'b1;
        send_word(32'h0000_0055);
        #1;
        chk("restart_count", count, 6);
        chk("restart_pkt", data_out, 7'h55);
        wait_refill(20);
        @(negedge clk);
        do_flush();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_unpack_ctrl.md
DATA_UNPACK_CTRL -- requirements
Module: data_unpack_ctrl

Interface
REQ-001 Parameters SHALL be: WORD_W, 32, input word width; PKT_W, 7, packet width; CNT_W, 5, datapath count width; only these defaults are supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream 32-bit word present on datapath data_in.
REQ-005 in_ready  output  1  controller accepts upstream word this cycle.
REQ-006 out_valid  output  1  datapath data_out holds a valid 7-bit packet.
REQ-007 out_ready  input  1  downstream accepts packet this cycle.
REQ-008 flush  input  1  synchronous restart of packet alignment; pending bits discarded.
REQ-009 count  input  5  datapath counter value.
REQ-010 data_rst, data_load, data_overflow_load, count_set, count_en  output  1 each  datapath controls.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Word transfer SHALL occur on in_valid & in_ready; packet transfer SHALL occur on out_valid & out_ready.
REQ-013 FSM states SHALL be IDLE, EMIT, REFILL; encoding is free.
REQ-014 IDLE: in_ready=1, out_valid=0; on word transfer, assert data_load, count_en, count_set (count becomes 6) and go to EMIT.
REQ-015 EMIT: out_valid=1; on packet transfer with count<=24, assert count_en (count+7) and stay in EMIT.
REQ-016 EMIT, packet transfer with count>=25: assert count_en (count wraps modulo 32 to count-25). If in_valid is also high, assert in_ready, data_load and data_overflow_load in the same cycle and stay in EMIT. Otherwise go to REFILL.
REQ-017 In EMIT, in_ready SHALL equal out_ready & (count>=25) & in_valid-independent; it is a combinational function of out_ready and count only.
REQ-018 REFILL: out_valid=0, in_ready=1; on word transfer, assert data_load and data_overflow_load (overflow captures old buffer bits 31:26 in the same edge) and go to EMIT.
REQ-019 data_load and data_overflow_load SHALL never be asserted outside a word transfer; data_overflow_load SHALL never be asserted from IDLE.
REQ-020 count_set SHALL be asserted only together with count_en.
REQ-021 flush SHALL override all handshakes in any state. It asserts data_rst, count_en and count_set, holds in_ready=0 and out_valid=0, and goes to IDLE. No transfer occurs in a flush cycle.
REQ-022 Latency: the first packet SHALL be valid one cycle after the first word transfer. Each subsequent packet within a word SHALL be valid in the cycle after the previous packet is accepted. A back-to-back refill SHALL cost zero bubble cycles.
REQ-023 out_valid, once high, SHALL remain high until transfer or flush.
REQ-024 Packets SHALL follow an LSB-first continuous bitstream. Seven words yield exactly 32 packets and return count to 6.

Reset
REQ-025 On rst_n low: state=IDLE. All datapath controls, in_ready, out_valid and busy SHALL be 0 while reset is asserted, even though IDLE otherwise drives in_ready=1.
REQ-026 On the first cycle after deassertion: in_ready=1 (IDLE). The datapath is first initialised by the IDLE load with count_set.
REQ-027 Reset mid-word SHALL discard all pending bits; no partial packet is emitted.

Structure
REQ-028 WORD_W, PKT_W, CNT_W, the refill threshold (WORD_W-PKT_W=25) and the state enum SHALL live in a shared package data_unpack_pkg.
REQ-029 The block SHALL be purely a controller with no data path. A top-level data_unpack_top instantiates it alongside the existing datapath; no further sub-module is needed.

Verification
REQ-030 Reset, then one word 0x0000007F with out_ready=1 -> first packet 0x7F one cycle after transfer, count=6; then stall in REFILL after packets at counts 6,13,20,27.
REQ-031 Seven words continuously valid, out_ready=1 -> 32 packets, no bubbles, count sequence 6,13,20,27,2,9,...,31,6; unpacked bits match the serialised words.
REQ-032 out_ready toggled randomly 50% -> no packet lost or duplicated; out_valid stable while stalled.
REQ-033 in_valid low at count=27 accept -> REFILL, out_valid=0. When the word arrives, the next packet = new[2:0] concatenated with old[31:28].
REQ-034 flush asserted in EMIT together with out_ready=1 and in_valid=1 -> no transfer, data_rst=1, IDLE next cycle.
REQ-035 rst_n asserted mid-EMIT (async, between edges) -> outputs 0 immediately; after release, a new word restarts at count 6.
